// File: rtl/vec_cfg_pkg.sv
// Shared vector-config definitions: sequencer state encoding, SEW codes and the
// vset* flavours understood by the config unit.
package vec_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CFG_WAIT = 2'd1,
    ST_RUN      = 2'd2
  } seq_state_t;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  typedef enum logic [1:0] {
    CFG_VSETVLI  = 2'd0,
    CFG_VSETIVLI = 2'd1,
    CFG_VSETVL   = 2'd2
  } cfg_type_t;

endpackage

// File: rtl/vl_seq_ctrl_if.sv
// Sequencer bus: vset* request, instruction request and the datapath beat stream.
// Handshake: a transfer happens in any cycle where valid and ready are both high.
interface vl_seq_ctrl_if #(
    parameter int VLEN_B_BITS = 12,
    parameter int ADDR_BITS   = 12,
    parameter int DW_B        = 8
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic                   cfg_en;
    logic [VLEN_B_BITS-1:0] avl;
    logic [1:0]             sew;
    logic                   vill;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [ADDR_BITS-1:0]   instr_base;
    logic                   flush;
    logic                   beat_valid;
    logic                   beat_ready;
    logic [ADDR_BITS-1:0]   beat_addr;
    logic [DW_B-1:0]        beat_be;
    logic                   beat_first;
    logic                   beat_last;
    logic                   instr_done;
    logic                   instr_err;
    logic                   busy;

    modport slave (
        input  cfg_valid, avl, sew, vill, instr_valid, instr_base, flush, beat_ready,
        output cfg_ready, cfg_en, instr_ready, beat_valid, beat_addr, beat_be,
               beat_first, beat_last, instr_done, instr_err, busy
    );

    modport master (
        output cfg_valid, avl, sew, vill, instr_valid, instr_base, flush, beat_ready,
        input  cfg_ready, cfg_en, instr_ready, beat_valid, beat_addr, beat_be,
               beat_first, beat_last, instr_done, instr_err, busy
    );
endinterface

// File: rtl/vl_beat_calc.sv
// Combinational vl/sew to beat geometry: total bytes, beat count and the byte
// mask of the final (possibly partial) beat.
module vl_beat_calc #(
    parameter int VLEN_B_BITS = 12,
    parameter int DATA_WIDTH  = 64
) (
    input  logic [VLEN_B_BITS-1:0]                       i_avl,
    input  logic [1:0]                                   i_sew,
    output logic [VLEN_B_BITS+2:0]                       o_tot_bytes,
    output logic [VLEN_B_BITS+2-$clog2(DATA_WIDTH/8):0] o_nbeats,
    output logic [DATA_WIDTH/8-1:0]                      o_tail_be
);
    localparam int DW_B      = DATA_WIDTH / 8;
    localparam int LOG_DWB   = $clog2(DW_B);
    localparam int TOT_BITS  = VLEN_B_BITS + 3;
    localparam int BEAT_BITS = TOT_BITS - LOG_DWB;

    logic [TOT_BITS:0]   w_round;
    logic [TOT_BITS-1:0] w_rem;

    // Three spare bits absorb the largest sew shift, so the product never overflows.
    assign o_tot_bytes = TOT_BITS'(i_avl) << i_sew;
    assign w_round     = {1'b0, o_tot_bytes} + (TOT_BITS+1)'(DW_B - 1);
    assign o_nbeats    = BEAT_BITS'(w_round >> LOG_DWB);
    assign w_rem       = o_tot_bytes & TOT_BITS'(DW_B - 1);
    assign o_tail_be   = (w_rem == '0) ? '1 : DW_B'((DW_B'(1) << w_rem) - DW_B'(1));
endmodule

// File: rtl/vl_seq_ctrl.sv
// Per-instruction element sequencer: arbitrates vset* requests against vector
// instructions and walks each accepted instruction out as datapath beats.
module vl_seq_ctrl
  import vec_cfg_pkg::*;
#(
    parameter int VLEN        = 16384,
    parameter int DATA_WIDTH  = 64,
    parameter int VLEN_B_BITS = 12,
    parameter int ADDR_BITS   = 12
) (
    input  logic          clk,
    input  logic          rst,
    vl_seq_ctrl_if.slave  bus,
    output seq_state_t    o_dbg_state
);
    localparam int DW_B      = DATA_WIDTH / 8;
    localparam int TOT_BITS  = VLEN_B_BITS + 3;
    localparam int BEAT_BITS = TOT_BITS - $clog2(DW_B);

    if (VLEN < DATA_WIDTH) begin : g_bad_cfg
        $error("vl_seq_ctrl: VLEN must be at least DATA_WIDTH");
    end

    seq_state_t           r_state, w_next;
    logic                 r_armed, r_done, r_err;
    logic [BEAT_BITS-1:0] r_cnt, r_last_idx;
    logic [ADDR_BITS-1:0] r_base;
    logic [DW_B-1:0]      r_tail_be;

    logic [TOT_BITS-1:0]  w_tot_bytes;
    logic [BEAT_BITS-1:0] w_nbeats;
    logic [DW_B-1:0]      w_tail_be;
    logic                 w_run, w_last, w_hs;
    logic                 w_cfg_acc, w_instr_acc, w_load, w_inc, w_done_n, w_err_n;

    vl_beat_calc #(.VLEN_B_BITS(VLEN_B_BITS), .DATA_WIDTH(DATA_WIDTH)) u_calc (
        .i_avl       (bus.avl),
        .i_sew       (bus.sew),
        .o_tot_bytes (w_tot_bytes),
        .o_nbeats    (w_nbeats),
        .o_tail_be   (w_tail_be)
    );

    assign w_run  = (r_state == ST_RUN);
    assign w_last = w_run && (r_cnt == r_last_idx);
    assign w_hs   = w_run && bus.beat_ready;

    // r_armed keeps every request ungranted during the first cycle after reset.
    always_comb begin
        w_next      = r_state;
        w_cfg_acc   = 1'b0;
        w_instr_acc = 1'b0;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        w_done_n    = 1'b0;
        w_err_n     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && !bus.flush) begin
                    if (bus.cfg_valid) begin
                        w_cfg_acc = 1'b1;
                        w_next    = ST_CFG_WAIT;
                    end else if (bus.instr_valid) begin
                        w_instr_acc = 1'b1;
                        if (bus.vill)                w_err_n  = 1'b1;
                        else if (w_tot_bytes == '0)  w_done_n = 1'b1;
                        else begin
                            w_load = 1'b1;
                            w_next = ST_RUN;
                        end
                    end
                end
            end
            ST_CFG_WAIT: w_next = ST_IDLE;
            ST_RUN: begin
                if (w_hs && !bus.flush) begin
                    if (w_last) begin
                        w_done_n = 1'b1;
                        w_next   = ST_IDLE;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (bus.flush) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_armed    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_last_idx <= '0;
            r_base     <= '0;
            r_tail_be  <= '0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            r_done  <= w_done_n;
            r_err   <= w_err_n;
            if (w_load) begin
                r_cnt      <= '0;
                r_last_idx <= w_nbeats - BEAT_BITS'(1);
                r_base     <= bus.instr_base;
                r_tail_be  <= w_tail_be;
            end else if (w_inc) begin
                r_cnt <= r_cnt + BEAT_BITS'(1);
            end
        end
    end

    assign bus.cfg_ready   = w_cfg_acc;
    assign bus.cfg_en      = w_cfg_acc;
    assign bus.instr_ready = w_instr_acc;
    assign bus.beat_valid  = w_run;
    assign bus.beat_addr   = w_run ? (r_base + ADDR_BITS'(r_cnt)) : '0;
    assign bus.beat_be     = w_run ? (w_last ? r_tail_be : '1) : '0;
    assign bus.beat_first  = w_run && (r_cnt == '0);
    assign bus.beat_last   = w_last;
    assign bus.instr_done  = r_done;
    assign bus.instr_err   = r_err;
    assign bus.busy        = (r_state != ST_IDLE);
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_vl_seq_ctrl.sv
// Bench for vl_seq_ctrl: directed scenarios plus random instructions, with a
// queue-based scoreboard fed by a reference model and drained by a monitor.
module tb_vl_seq_ctrl;
  import vec_cfg_pkg::*;

  localparam logic [1:0] EV_BEAT = 2'd0;
  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  logic clk = 1'b0;
  logic rst;
  seq_state_t dbg_state;

  always #5 clk = ~clk;

  vl_seq_ctrl_if #(.VLEN_B_BITS(12), .ADDR_BITS(12), .DW_B(8)) bus ();

  vl_seq_ctrl #(.VLEN(16384), .DATA_WIDTH(64), .VLEN_B_BITS(12), .ADDR_BITS(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [23:0] exp_q[$];

  int rdy_mode = 0;
  int pidx = 0;
  bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  function automatic logic [23:0] mk_ev(logic [1:0] k, logic [11:0] a, logic [7:0] be,
                                        logic f, logic l);
    return {k, a, be, f, l};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic sb_pop(string name, logic [23:0] got);
    logic [23:0] e;
    n_total++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s unexpected event got=%h exp=none t=%0t", name, got, $time);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s got=%h exp=%h t=%0t", name, got, e, $time);
      end
    end
  endtask

  // Reference: byte count -> beats of 8 bytes, partial tail, address wraps at 4096.
  task automatic model_push(int avl, int sew, int base, bit vill, int keep);
    int nbytes, nb, rem;
    logic [7:0] be;
    if (vill) begin
      exp_q.push_back(mk_ev(EV_ERR, 12'h0, 8'h0, 1'b0, 1'b0));
      return;
    end
    nbytes = avl * (1 << sew);
    if (nbytes == 0) begin
      exp_q.push_back(mk_ev(EV_DONE, 12'h0, 8'h0, 1'b0, 1'b0));
      return;
    end
    nb  = (nbytes + 7) / 8;
    rem = nbytes % 8;
    for (int i = 0; i < nb; i++) begin
      if (keep >= 0 && i >= keep) return;
      be = (i == nb - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
      exp_q.push_back(mk_ev(EV_BEAT, 12'((base + i) % 4096), be, i == 0, i == nb - 1));
    end
    if (keep < 0) exp_q.push_back(mk_ev(EV_DONE, 12'h0, 8'h0, 1'b0, 1'b0));
  endtask

  // Monitor: pops on every observed event, checks stall stability and pulse latency.
  logic        p_stall = 1'b0, p_done_ok = 1'b0, p_err_ok = 1'b0;
  logic [23:0] p_beat = '0;
  always @(negedge clk) begin
    logic [23:0] cur;
    if (rst) begin
      p_stall   = 1'b0;
      p_done_ok = 1'b0;
      p_err_ok  = 1'b0;
    end else begin
      cur = mk_ev(EV_BEAT, bus.beat_addr, bus.beat_be, bus.beat_first, bus.beat_last);
      if (p_stall) begin
        chk("hold_valid", 32'(bus.beat_valid), 32'd1);
        chk("hold_beat", 32'(cur), 32'(p_beat));
      end
      if (bus.beat_valid && bus.beat_ready) sb_pop("beat", cur);
      if (bus.instr_done) begin
        chk("done_latency", 32'(p_done_ok), 32'd1);
        sb_pop("done", mk_ev(EV_DONE, 12'h0, 8'h0, 1'b0, 1'b0));
      end
      if (bus.instr_err) begin
        chk("err_latency", 32'(p_err_ok), 32'd1);
        sb_pop("err", mk_ev(EV_ERR, 12'h0, 8'h0, 1'b0, 1'b0));
      end
      p_stall   = bus.beat_valid && !bus.beat_ready && !bus.flush;
      p_beat    = cur;
      p_done_ok = (bus.beat_valid && bus.beat_ready && bus.beat_last && !bus.flush) ||
                  (bus.instr_ready && !bus.vill && bus.avl == 12'd0);
      p_err_ok  = bus.instr_ready && bus.vill;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.beat_ready = 1'b1;
      1: bus.beat_ready = 1'($urandom_range(0, 1));
      default: if (bus.beat_valid) begin
        bus.beat_ready = pat[pidx % 4];
        pidx++;
      end
    endcase
  end

  task automatic wait_drain(int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_in_time", 32'(ok), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic issue(int avl, int sew, int base, bit vill);
    bus.avl         = 12'(avl);
    bus.sew         = 2'(sew);
    bus.instr_base  = 12'(base);
    bus.vill        = vill;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    chk("instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("cfg_en_quiet", 32'(bus.cfg_en), 32'd0);
    model_push(avl, sew, base, vill, -1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.vill        = 1'b0;
    wait_drain(10000);
  endtask

  task automatic find_addr(logic [11:0] a);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.beat_valid && bus.beat_addr == a) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("find_beat", 32'(found), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.cfg_valid = 1'b1; bus.instr_valid = 1'b1; bus.flush = 1'b0;
    bus.avl = 12'd5; bus.sew = 2'd0; bus.vill = 1'b0; bus.instr_base = 12'h0;
    #3;
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    chk("rst_cfg_en", 32'(bus.cfg_en), 32'd0);
    chk("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
    chk("rst_beat_valid", 32'(bus.beat_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    chk("post_rst_instr_ready", 32'(bus.instr_ready), 32'd0);
    chk("post_rst_done", 32'(bus.instr_done), 32'd0);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0; bus.instr_valid = 1'b0;
    @(posedge clk); #1;

    rdy_mode = 0;
    issue(13, 1, 12'h010, 1'b0);

    rdy_mode = 2; pidx = 0;
    issue(16, 0, 12'h020, 1'b0);
    rdy_mode = 0;

    // vset* and instruction together: cfg wins, instruction waits out CFG_WAIT.
    bus.cfg_valid = 1'b1; bus.instr_valid = 1'b1;
    bus.avl = 12'd3; bus.sew = 2'd0; bus.instr_base = 12'h050; bus.vill = 1'b0;
    @(negedge clk);
    chk("cfg_en", 32'(bus.cfg_en), 32'd1);
    chk("cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("cfg_blocks_instr", 32'(bus.instr_ready), 32'd0);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0; bus.avl = 12'd20; bus.sew = 2'd2;
    @(negedge clk);
    chk("cfgw_state", 32'(dbg_state), 32'(ST_CFG_WAIT));
    chk("cfgw_instr_ready", 32'(bus.instr_ready), 32'd0);
    chk("cfgw_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    chk("cfgw_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cfg_then_instr", 32'(bus.instr_ready), 32'd1);
    model_push(20, 2, 12'h050, 1'b0, -1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    wait_drain(200);

    issue(5, 2, 12'h030, 1'b1);
    issue(0, 1, 12'h040, 1'b0);
    issue(4, 3, 12'hFFE, 1'b0);

    // Back-to-back: the second instruction is granted in the first one's done cycle.
    bus.avl = 12'd8; bus.sew = 2'd0; bus.instr_base = 12'h060; bus.instr_valid = 1'b1;
    @(negedge clk);
    chk("b2b_first_ready", 32'(bus.instr_ready), 32'd1);
    model_push(8, 0, 12'h060, 1'b0, -1);
    @(posedge clk); #1;
    bus.avl = 12'd3; bus.sew = 2'd1; bus.instr_base = 12'h070;
    @(negedge clk);
    chk("b2b_run_ready", 32'(bus.instr_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_done", 32'(bus.instr_done), 32'd1);
    chk("b2b_ready", 32'(bus.instr_ready), 32'd1);
    model_push(3, 1, 12'h070, 1'b0, -1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    wait_drain(200);

    // Flush on beat 1 while it is accepted: beat 1 counts, no done.
    bus.avl = 12'd32; bus.sew = 2'd0; bus.instr_base = 12'h100; bus.instr_valid = 1'b1;
    @(negedge clk);
    chk("flush_instr_ready", 32'(bus.instr_ready), 32'd1);
    model_push(32, 0, 12'h100, 1'b0, 2);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    find_addr(12'h101);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_valid", 32'(bus.beat_valid), 32'd0);
    chk("flush_busy", 32'(bus.busy), 32'd0);
    wait_drain(200);

    // Reset while beat 2 is presented: abandoned without a done pulse.
    bus.avl = 12'd32; bus.sew = 2'd0; bus.instr_base = 12'h200; bus.instr_valid = 1'b1;
    @(negedge clk);
    chk("rstrun_instr_ready", 32'(bus.instr_ready), 32'd1);
    model_push(32, 0, 12'h200, 1'b0, 2);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    find_addr(12'h202);
    rst = 1'b1;
    #1;
    chk("rstrun_valid", 32'(bus.beat_valid), 32'd0);
    chk("rstrun_busy", 32'(bus.busy), 32'd0);
    chk("rstrun_done", 32'(bus.instr_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_drain(200);

    rdy_mode = 1;
    for (int i = 0; i < 30; i++) begin
      issue(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40),
            $urandom_range(0, 3), $urandom_range(0, 4095),
            ($urandom_range(0, 7) == 0));
    end
    issue(4095, 0, $urandom_range(0, 4095), 1'b0);
    rdy_mode = 0;
    issue(4095, 3, 12'hF00, 1'b0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/vl_seq_ctrl.md
Name: vl_seq_ctrl

Overview:
- Per-instruction element sequencer for the vector datapath.
- Arbitrates between vset* configuration requests, which it issues to the config unit by driving its enable, and vector-instruction execution.
- For each accepted instruction it converts the current vl/sew into DATA_WIDTH-wide beats, emitting per beat:
  - register-file address;
  - tail byte-enable;
  - first/last flags.
- It is the only block that drives the config unit enable and the datapath beat stream.

Parameters:
- VLEN, 16384, vector register length in bits
- DATA_WIDTH, 64, datapath beat width in bits (power of two, >= 8)
- VLEN_B_BITS, 12, width of avl
- ADDR_BITS, 12, width of register-file beat address
- DW_B, DATA_WIDTH/8 (derived localparam), bytes per beat
- BEAT_BITS, VLEN_B_BITS+3-log2(DW_B) (derived localparam), beat counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_valid  in  1  vset* request pending
- cfg_ready  out  1  request accepted this cycle
- cfg_en  out  1  enable pulse to config unit
- avl  in  VLEN_B_BITS  current vl from config unit
- sew  in  2  current sew (0=8b, 1=16b, 2=32b, 3=64b)
- vill  in  1  current vtype illegal
- instr_valid  in  1  vector instruction pending
- instr_ready  out  1  instruction accepted this cycle
- instr_base  in  ADDR_BITS  destination group base beat address
- flush  in  1  synchronous abort
- beat_valid  out  1  beat presented
- beat_ready  in  1  datapath accepts beat
- beat_addr  out  ADDR_BITS  instr_base + beat index, mod 2^ADDR_BITS
- beat_be  out  DW_B  byte enables
- beat_first  out  1  first beat of instruction
- beat_last  out  1  last beat of instruction
- instr_done  out  1  one-cycle pulse, instruction completed
- instr_err  out  1  one-cycle pulse, instruction rejected (vill)
- busy  out  1  state != IDLE

Behaviour:
- Reset: async, state=IDLE, counters=0. All outputs 0 while rst is high and in the first cycle after release. Reset mid-RUN abandons the instruction with no done/err pulse.
- States: IDLE, CFG_WAIT, RUN.
- IDLE, priority cfg > instr:
  - cfg_valid: cfg_ready=cfg_en=1 (combinational, same cycle) -> CFG_WAIT.
  - else instr_valid: instr_ready=1 (combinational), then:
    - vill=1: instr_err pulses the next cycle; stay IDLE.
    - avl=0: instr_done pulses the next cycle; stay IDLE; no beats.
    - otherwise: latch sew, instr_base, tot_bytes = avl<<sew (VLEN_B_BITS+3 bits, no overflow), and nbeats = ceil(tot_bytes/DW_B); beat_cnt=0 -> RUN.
- CFG_WAIT: exactly one cycle, in which the config unit's new avl/sew settle; cfg_ready and instr_ready are 0 -> IDLE. An instruction is therefore never accepted with stale vl.
- RUN:
  - beat_valid=1; beat_addr = base + beat_cnt (wraps modulo 2^ADDR_BITS); beat_first = (beat_cnt==0); beat_last = (beat_cnt==nbeats-1).
  - beat_be is all ones, except on the last beat when r = tot_bytes mod DW_B is nonzero: then (1<<r)-1.
  - Outputs hold stable while beat_valid & ~beat_ready.
  - A handshake on a non-last beat increments beat_cnt.
  - A handshake on the last beat pulses instr_done the next cycle -> IDLE.
  - cfg_ready=instr_ready=0 throughout RUN.
- flush: in any state, next state is IDLE, beat_valid drops next cycle, no done pulse. flush has priority over handshakes in the same cycle; a beat accepted that cycle still counts as transferred to the datapath.
- Single-beat instruction: first and last are both 1.
- Throughput: back-to-back instructions have one IDLE cycle between them (done cycle = accept cycle).

Decomposition:
- Shared package vec_cfg_pkg holds:
  - state enum (IDLE, CFG_WAIT, RUN);
  - sew encoding constants;
  - cfg_type encodings shared with the config unit.
- One natural sub-module: vl_beat_calc. It is combinational and computes tot_bytes, nbeats and tail mask from avl/sew; it is reused by the load/store sequencer.

Test Plan (DATA_WIDTH=64, DW_B=8):
- avl=13, sew=1, base=0x010, beat_ready=1 -> 4 beats:
  - addr 0x010..0x013, first on beat 0, last on beat 3;
  - be FF,FF,FF,03;
  - instr_done one cycle after beat 3.
- avl=16, sew=0, beat_ready toggling 1,0,0,1 -> 2 beats, both be=FF; addr/be held during stalls; done after the 2nd handshake.
- cfg_valid and instr_valid asserted together in IDLE -> cfg_en=1 that cycle, instr_ready=0; one CFG_WAIT cycle; instr accepted the following cycle using the new avl.
- vill=1 with instr_valid -> instr_ready=1, instr_err pulses next cycle, no beat_valid. avl=0 -> done pulse only.
- base=0xFFE, avl=4, sew=3 -> 4 beats, addr FFE, FFF, 000, 001 (wrap).
- Mid-RUN disruption:
  - rst asserted at beat 2 of 4 -> beat_valid=0 immediately, busy=0, no done.
  - separate run, flush at beat 1 -> IDLE next cycle, no done.
